// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480 timing constants, pattern encoding, box limits
// and colour constants for the pixel pipeline.
package vga_pkg;
    localparam int VGA_H_BACK_PORCH = 48;
    localparam int VGA_H_VISIBLE    = 640;
    localparam int VGA_V_BACK_PORCH = 33;
    localparam int VGA_V_VISIBLE    = 480;

    typedef enum logic [1:0] {
        PAT_WHITE = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_BOX   = 2'd3
    } pat_e;

    localparam int BOX_SIZE  = 64;
    localparam int BOX_X_MAX = 576;
    localparam int BOX_Y_MAX = 416;

    localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
    localparam logic [23:0] RGB_BLACK = 24'h000000;
    localparam logic [23:0] RGB_BOX   = 24'hFF0000;
    localparam logic [23:0] RGB_BG    = 24'h000040;

    // Bar i lights red/green/blue from bits 2/1/0 of its index.
    function automatic logic [23:0] bar_rgb(input logic [2:0] i);
        return {{8{i[2]}}, {8{i[1]}}, {8{i[0]}}};
    endfunction
endpackage

// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if: sync inputs, pattern select and pixel outputs of the
// pattern generator; master drives syncs, slave is the generator.
interface vga_pattern_gen_if;
    logic        hsync;
    logic        vsync;
    logic [1:0]  pattern_sel;
    logic        hsync_out;
    logic        vsync_out;
    logic        de;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic [9:0]  x_val;
    logic [9:0]  y_val;
    logic [15:0] frame_count;

    modport master (
        output hsync, vsync, pattern_sel,
        input  hsync_out, vsync_out, de, red, green, blue, x_val, y_val, frame_count
    );
    modport slave (
        input  hsync, vsync, pattern_sel,
        output hsync_out, vsync_out, de, red, green, blue, x_val, y_val, frame_count
    );
endinterface

// File: rtl/vga_box_mover.sv
// vga_box_mover: bouncing box position, one step per axis on each frame_tick,
// landing on a bound before reversing direction.
module vga_box_mover
    import vga_pkg::*;
#(
    parameter int X_MAX = BOX_X_MAX,
    parameter int Y_MAX = BOX_Y_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick_i,
    output logic [9:0] box_x_o,
    output logic [9:0] box_y_o
);
    logic [9:0] x_q, x_d, y_q, y_d;
    logic       dx_q, dx_d, dy_q, dy_d;

    // Direction bit set means moving toward zero.
    always_comb begin
        x_d  = dx_q ? x_q - 10'd1 : x_q + 10'd1;
        y_d  = dy_q ? y_q - 10'd1 : y_q + 10'd1;
        dx_d = dx_q ? (x_d != 10'd0) : (x_d == 10'(X_MAX));
        dy_d = dy_q ? (y_d != 10'd0) : (y_d == 10'(Y_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q  <= '0;
            y_q  <= '0;
            dx_q <= 1'b0;
            dy_q <= 1'b0;
        end else if (frame_tick_i) begin
            x_q  <= x_d;
            y_q  <= y_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    assign box_x_o = x_q;
    assign box_y_o = y_q;
endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: rebuilds pixel position from sync edges and emits a
// registered RGB test pattern with data-enable and syncs delayed two clocks.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_BACK_PORCH = VGA_H_BACK_PORCH,
    parameter int H_VISIBLE    = VGA_H_VISIBLE,
    parameter int V_BACK_PORCH = VGA_V_BACK_PORCH,
    parameter int V_VISIBLE    = VGA_V_VISIBLE
) (
    input logic               clk,
    input logic               rst_n,
    vga_pattern_gen_if.slave  bus
);
    logic        hsync_q, vsync_q, hs_out_q, vs_out_q;
    logic        h_rise, v_rise, vis, in_box, de_q;
    logic [10:0] h_pos_q, h_pos_d, v_pos_q, v_pos_d;
    logic [1:0]  pat_q;
    logic [15:0] fc_q;
    logic [23:0] rgb_q, rgb_d;
    logic [9:0]  x, y, x_q, y_q, box_x, box_y;

    assign h_rise = bus.hsync & ~hsync_q;
    assign v_rise = bus.vsync & ~vsync_q;

    vga_box_mover u_box (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick_i (v_rise),
        .box_x_o      (box_x),
        .box_y_o      (box_y)
    );

    // Positions saturate at all-ones so a lost sync can never wrap into view.
    always_comb begin
        h_pos_d = h_rise ? '0 : h_pos_q + {10'd0, ~&h_pos_q};
        v_pos_d = v_rise ? '0 : v_pos_q + {10'd0, h_rise & ~&v_pos_q};
        x       = 10'(h_pos_q - 11'(H_BACK_PORCH));
        y       = 10'(v_pos_q - 11'(V_BACK_PORCH));
        vis     = h_pos_q >= 11'(H_BACK_PORCH) && h_pos_q < 11'(H_BACK_PORCH + H_VISIBLE)
               && v_pos_q >= 11'(V_BACK_PORCH) && v_pos_q < 11'(V_BACK_PORCH + V_VISIBLE);
        in_box  = x >= box_x && {1'b0, x} < {1'b0, box_x} + 11'(BOX_SIZE)
               && y >= box_y && {1'b0, y} < {1'b0, box_y} + 11'(BOX_SIZE);
        rgb_d   = pat_q == PAT_WHITE ? RGB_WHITE
                : pat_q == PAT_BARS  ? bar_rgb(3'(x / 10'd80))
                : pat_q == PAT_CHECK ? ((x[5] ^ y[5]) ? RGB_WHITE : RGB_BLACK)
                : in_box             ? RGB_BOX : RGB_BG;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            hs_out_q <= 1'b1;
            vs_out_q <= 1'b1;
            h_pos_q  <= '1;
            v_pos_q  <= '1;
            pat_q    <= '0;
            fc_q     <= '0;
            de_q     <= 1'b0;
            rgb_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            hsync_q  <= bus.hsync;
            vsync_q  <= bus.vsync;
            hs_out_q <= hsync_q;
            vs_out_q <= vsync_q;
            h_pos_q  <= h_pos_d;
            v_pos_q  <= v_pos_d;
            if (v_rise) begin
                pat_q <= bus.pattern_sel;
                fc_q  <= fc_q + 16'd1;
            end
            de_q  <= vis;
            rgb_q <= vis ? rgb_d : '0;
            x_q   <= vis ? x : '0;
            y_q   <= vis ? y : '0;
        end
    end

    assign bus.hsync_out   = hs_out_q;
    assign bus.vsync_out   = vs_out_q;
    assign bus.de          = de_q;
    assign bus.red         = rgb_q[23:16];
    assign bus.green       = rgb_q[15:8];
    assign bus.blue        = rgb_q[7:0];
    assign bus.x_val       = x_q;
    assign bus.y_val       = y_q;
    assign bus.frame_count = fc_q;
endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Downstream pixel stage for the `vga` timing generator. It consumes the registered `hsync`/`vsync` it produces and rebuilds horizontal and vertical pixel positions from the sync rising edges. It then emits a registered 24-bit RGB test pattern plus a data-enable and sync outputs delayed to match. It is the first block that drives colour pins and the bring-up source for the 640x480@60 board output.

## Interface
- `H_BACK_PORCH`, 48: clocks from hsync rising edge to first visible pixel.
- `H_VISIBLE`, 640: visible pixels per line.
- `V_BACK_PORCH`, 33: lines from vsync rising edge to first visible line.
- `V_VISIBLE`, 480: visible lines per frame.
- `clk`  in  1  dot clock (25.175 MHz nominal), same clock as the timing generator.
- `rst_n`  in  1  asynchronous, active-low reset.
- `hsync`  in  1  active-low horizontal sync from the timing generator.
- `vsync`  in  1  active-low vertical sync from the timing generator.
- `pattern_sel`  in  2  0 = white, 1 = colour bars, 2 = checkerboard, 3 = bouncing box.
- `hsync_out`, `vsync_out`  out  1 each  sync inputs delayed 2 clocks.
- `de`  out  1  high on visible pixels.
- `red`, `green`, `blue`  out  8 each  pixel colour; 0 whenever `de` = 0.
- `x_val`  out  10  visible column 0..639; 0 when `de` = 0.
- `y_val`  out  10  visible row 0..479; 0 when `de` = 0.
- `frame_count`  out  16  count of vsync rising edges; wraps.

## Operation
- **Sync sampling.** `hsync_q` and `vsync_q` register the inputs.
  - Rising edge: input = 1 and `_q` = 0.
  - Both registers reset to 1, so no edge is detected on the first cycle after reset.
- **`h_pos` (11 bit).**
  - Loads 0 on an hsync rising edge.
  - Otherwise increments, saturating at 2047.
- **`v_pos` (11 bit).**
  - Loads 0 on a vsync rising edge.
  - Otherwise increments on each hsync rising edge, saturating at 2047.
  - If both edges occur in the same cycle, vsync wins: `v_pos` loads 0.
- **Positions after reset.** `h_pos` and `v_pos` reset to 2047 (not visible). Output stays black until the first vsync edge followed by 33 line edges.
- **Visibility.**
  - Visible when `H_BACK_PORCH` ≤ `h_pos` < `H_BACK_PORCH + H_VISIBLE` and `V_BACK_PORCH` ≤ `v_pos` < `V_BACK_PORCH + V_VISIBLE`.
  - x = `h_pos` − `H_BACK_PORCH`, y = `v_pos` − `V_BACK_PORCH`, both truncated to 10 bits.
- **Patterns.**
  - 0: FFFFFF.
  - 1: eight 80-px bars indexed by x/80. Bar i has red = i[2], green = i[1], blue = i[0], each channel 00 or FF. Bar 0 is black, bar 7 is white.
  - 2: checkerboard of 32x32 squares; FFFFFF where x[5] XOR y[5] = 1, else 000000.
  - 3: 64x64 FF0000 box at (`box_x`, `box_y`) on a 000040 background. A pixel is inside when `box_x` ≤ x < `box_x` + 64 and likewise for y.
- **Frame-boundary updates.** On each vsync rising edge:
  - `pattern_sel` is captured into `pat_q`, so no mid-frame tearing.
  - `frame_count` increments.
  - The box steps ±1 on each axis. `box_x` bounces in 0..576 and `box_y` in 0..416.
  - When the box reaches a bound, that step lands on the bound and the direction flips for the next frame.
- **Reset state.** `pat_q` = 0, box at (0,0), directions +x and +y, `frame_count` = 0.

## Timing
- Latency is 2 clocks from the sync inputs to all outputs:
  - Cycle t: the sync input changes.
  - Cycle t+1: `h_pos`/`v_pos` reflect that change.
  - Cycle t+2: `de`/RGB/`x_val`/`y_val` register from the positions, together with `hsync_out`/`vsync_out`.
- A pixel with `h_pos` = 48 appears at the output exactly 48 clocks after `hsync_out` rises.
- `pat_q` and the box take their new values on the vsync-edge cycle and affect pixels from the next clock. All such pixels lie in vertical blanking.
- Reset values of outputs: `hsync_out` = 1, `vsync_out` = 1, everything else 0.
- Asserting `rst_n` mid-frame forces the reset values immediately. Recovery then follows the after-reset sequence above.

## Structure
- Shared `vga_pkg` holds:
  - the 640x480 timing constants,
  - the pattern-select encoding,
  - the box size (64) and its limits (576/416),
  - the colour constants.
- Sub-module `vga_box_mover` contains the box position/direction registers, stepped by a one-cycle `frame_tick`. It is reusable by later sprite logic.
- Everything else lives in a single module.

## Test plan
- **Reset hold.** Hold `rst_n` = 0 with syncs toggling. Expect `hsync_out` = `vsync_out` = 1, RGB = 0, `de` = 0. Release, drive one full frame from the real `vga` instance: `de` stays 0 until the first complete back porch, then is high for exactly 640x480 clocks per frame.
- **Colour-bar boundary.** Pattern 1: x = 79 → 000000, x = 80 → 0000FF, x = 639 → FFFFFF. The first `de` on a line comes 48 clocks after `hsync_out` rises.
- **Checkerboard corners.** Pattern 2: (31,31) → 000000, (32,0) → FFFFFF, (32,32) → 000000.
- **Mid-frame select change.** Change `pattern_sel` 0→2 at y = 200. The rest of the frame stays white; the next frame is checkerboard.
- **Box bounce.** Pattern 3, run 600 frames:
  - `box_x` reaches 576 at frame 576 and is 575 at frame 577.
  - `box_y` peaks at 416 at frame 416.
  - `frame_count` = 600.
- **Simultaneous edges and mid-run reset.**
  - Drive hsync and vsync rising on the same clock: `v_pos` = 0.
  - Assert `rst_n` for 3 clocks mid-line: outputs return to reset values the same cycle, and `frame_count` = 0.
